neuron_scheduler: RTL and testbench

- Time-multiplexes one leaky integrate-and-fire update across NUM_NEURONS virtual neurons.
- Per-neuron membrane state and last-spike flag are held in an internal register array.
- Each timestep is triggered by step_start. The block then walks neurons 0..N-1 in order:
  - pulls one post-synaptic value per neuron through a valid/ready input stream;
  - pushes one spike result per neuron through a valid/ready output stream.
- Sits between the synapse/crossbar accumulator (producer) and the spike router (consumer).
- Threshold is runtime-configurable while idle.

---
 rtl/neuron_scheduler_pkg.sv | 15 +
 rtl/neuron_scheduler_lif_update.sv | 28 ++
 rtl/neuron_scheduler.sv | 122 ++++++++++++
 tb/tb_neuron_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_scheduler_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM encoding and default sizing.
package neuron_scheduler_pkg;

  localparam int DEF_STATE_W      = 8;
  localparam int DEF_DECAY_SHIFT  = 4;
  localparam int DEF_THRESH_RESET = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/neuron_scheduler_lif_update.sv
// Combinational leaky integrate-and-fire update: leak, saturating add, spike test.
// Zero latency; no flow control of its own.
module lif_update
  import neuron_scheduler_pkg::*;
#(
  parameter int STATE_W     = DEF_STATE_W,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT
) (
  input  logic [STATE_W-1:0] s,
  input  logic               p,
  input  logic [STATE_W-1:0] x,
  input  logic [STATE_W-1:0] threshold,
  output logic [STATE_W-1:0] s_next,
  output logic               p_next
);

  logic [STATE_W-1:0] carried;
  logic [STATE_W:0]   sum;

  // A neuron that spiked last step carries nothing forward (post-spike reset).
  always_comb begin
    carried = p ? '0 : (s >> DECAY_SHIFT);
    sum     = {1'b0, x} + {1'b0, carried};
    s_next  = sum[STATE_W] ? '1 : sum[STATE_W-1:0];
    p_next  = (s >= threshold);
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexed LIF scheduler; step_start -> step_done takes 2*NUM_NEURONS+1 cycles unstalled.
// Stalls in FETCH while in_valid is low and in EMIT while out_ready is low.
module neuron_scheduler
  import neuron_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS  = 4,
  parameter int STATE_W      = DEF_STATE_W,
  parameter int DECAY_SHIFT  = DEF_DECAY_SHIFT,
  parameter int THRESH_RESET = DEF_THRESH_RESET,
  parameter int IDX_W        = $clog2(NUM_NEURONS),
  parameter int CNT_W        = $clog2(NUM_NEURONS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_start,
  input  logic               clear_state,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_threshold,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [IDX_W-1:0]   in_idx,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_spike,
  output logic               busy,
  output logic               step_done,
  output logic [CNT_W-1:0]   spike_count,
  output logic [STATE_W-1:0] threshold
);

  sched_state_t             fsm;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         count;
  logic [STATE_W-1:0]       mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]   flag;
  logic [STATE_W-1:0]       upd_state;
  logic                     upd_spike;

  assign in_idx = idx;

  lif_update #(
    .STATE_W     (STATE_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_lif (
    .s         (mem[idx]),
    .p         (flag[idx]),
    .x         (in_data),
    .threshold (threshold),
    .s_next    (upd_state),
    .p_next    (upd_spike)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm         <= ST_IDLE;
      idx         <= '0;
      count       <= '0;
      threshold   <= STATE_W'(THRESH_RESET);
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_spike   <= 1'b0;
      busy        <= 1'b0;
      step_done   <= 1'b0;
      spike_count <= '0;
      flag        <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
    end else begin
      step_done <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          // Threshold lands before the first FETCH, so a same-cycle step uses it.
          if (cfg_we) threshold <= cfg_threshold;
          if (step_start) begin
            fsm      <= ST_FETCH;
            idx      <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (clear_state) begin
            flag <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= '0;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            mem[idx]  <= upd_state;
            flag[idx] <= upd_spike;
            out_idx   <= idx;
            out_spike <= upd_spike;
            count     <= count + CNT_W'(upd_spike);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            fsm       <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_W'(NUM_NEURONS - 1)) begin
              fsm         <= ST_DONE;
              step_done   <= 1'b1;
              spike_count <= count;
            end else begin
              idx      <= idx + 1'b1;
              in_ready <= 1'b1;
              fsm      <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy <= 1'b0;
          fsm  <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Randomised and directed bench for neuron_scheduler against a queue-based LIF model.
module tb_neuron_scheduler;

  localparam int N    = 4;
  localparam int SW   = 8;
  localparam int DS   = 4;
  localparam int IW   = 2;
  localparam int CW   = 3;
  localparam int SMAX = 255;

  logic          clk;
  logic          reset;
  logic          step_start;
  logic          clear_state;
  logic          cfg_we;
  logic [SW-1:0] cfg_threshold;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic [SW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_spike;
  logic          busy;
  logic          step_done;
  logic [CW-1:0] spike_count;
  logic [SW-1:0] threshold;

  neuron_scheduler #(.NUM_NEURONS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .step_start    (step_start),
    .clear_state   (clear_state),
    .cfg_we        (cfg_we),
    .cfg_threshold (cfg_threshold),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_idx        (in_idx),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_idx       (out_idx),
    .out_spike     (out_spike),
    .busy          (busy),
    .step_done     (step_done),
    .spike_count   (spike_count),
    .threshold     (threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-neuron state/flag, threshold, expected result stream.
  typedef struct { int idx; int spk; } exp_t;
  exp_t         exp_q[$];
  int           m_s[N];
  int           m_p[N];
  int           m_thr;
  int           m_cnt;
  int           stim[N];
  int           in_st[N];
  int           out_st[N];
  int           t0;
  bit           done_allowed;
  logic [N-1:0] got_spk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_s[i] = 0; m_p[i] = 0; end
    m_thr = 32;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin m_s[i] = 0; m_p[i] = 0; end
  endfunction

  function automatic void model_step();
    int spk, leak, sum;
    m_cnt = 0;
    for (int i = 0; i < N; i++) begin
      spk    = (m_s[i] >= m_thr) ? 1 : 0;
      leak   = (m_p[i] != 0) ? 0 : (m_s[i] >> DS);
      sum    = stim[i] + leak;
      m_s[i] = (sum > SMAX) ? SMAX : sum;
      m_p[i] = spk;
      m_cnt += spk;
      exp_q.push_back('{idx: i, spk: spk});
    end
  endfunction

  function automatic void set_stim(input int a, input int b, input int c, input int d);
    stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = d;
  endfunction

  function automatic void no_stalls();
    for (int i = 0; i < N; i++) begin in_st[i] = 0; out_st[i] = 0; end
  endfunction

  // One compare process: checks stream outputs against the model every cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("in_out_exclusive", 32'(in_ready & out_valid), 0);
      chk("busy_vs_state", 32'(busy), 32'(in_ready | out_valid | step_done));
      if (in_ready) begin
        if (exp_q.size() == 0) chk("in_ready_unexpected", 32'(in_ready), 0);
        else chk("in_idx", 32'(in_idx), exp_q[0].idx);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", 32'(out_valid), 0);
        else begin
          chk("out_idx", 32'(out_idx), exp_q[0].idx);
          chk("out_spike", 32'(out_spike), exp_q[0].spk);
          if (out_ready) begin
            got_spk[out_idx] = out_spike;
            void'(exp_q.pop_front());
          end
        end
      end
      if (step_done) chk("step_done_allowed", 32'(done_allowed), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [SW-1:0] d, input int s);
    bit got;
    in_valid = 1'b0;
    repeat (s) begin
      @(negedge clk);
      chk("fetch_hold_ready", 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    got      = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    chk("in_handshake", 32'(got), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_out(input int s);
    bit got;
    out_ready = 1'b0;
    repeat (s) begin
      @(negedge clk);
      chk("emit_hold_valid", 32'(out_valid), 1);
      chk("emit_hold_no_in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    got       = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk("out_handshake", 32'(got), 1);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_step(input bit do_cfg, input int cfg_v, input bit do_clr, input bit junk);
    int stalls;
    bit got;
    if (do_cfg) m_thr = cfg_v;
    model_step();
    tick();
    step_start    = 1'b1;
    cfg_we        = do_cfg;
    cfg_threshold = SW'(cfg_v);
    clear_state   = do_clr;
    t0            = cyc;
    tick();
    step_start  = 1'b0;
    cfg_we      = 1'b0;
    clear_state = 1'b0;
    stalls      = 0;
    for (int i = 0; i < N; i++) begin
      if (junk && i == 1) begin
        step_start = 1'b1; clear_state = 1'b1; cfg_we = 1'b1; cfg_threshold = 8'd10;
      end
      stalls += in_st[i] + out_st[i];
      feed(SW'(stim[i]), in_st[i]);
      do_out(out_st[i]);
      if (junk && i == 1) begin
        step_start = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
      end
    end
    done_allowed = 1'b1;
    got          = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (step_done) got = 1'b1;
    end
    chk("step_done_seen", 32'(got), 1);
    if (got) chk("step_latency", cyc - t0, 2 * N + 1 + stalls);
    @(negedge clk);
    chk("spike_count", 32'(spike_count), m_cnt);
    chk("idle_busy", 32'(busy), 0);
    chk("threshold", 32'(threshold), m_thr);
    tick();
    done_allowed = 1'b0;
  endtask

  task automatic cfg_only(input int v);
    tick();
    cfg_we = 1'b1; cfg_threshold = SW'(v);
    tick();
    cfg_we = 1'b0;
    m_thr  = v;
  endtask

  task automatic clear_only();
    tick();
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    model_clear();
  endtask

  task automatic abort_step();
    set_stim(0, 0, 0, 0);
    model_step();
    tick();
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      feed(SW'(stim[i]), 0);
      do_out(0);
    end
    feed(SW'(stim[2]), 0);
    @(negedge clk);
    chk("abort_emit_idx", 32'(out_idx), 2);
    chk("abort_emit_valid", 32'(out_valid), 1);
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_step_done", 32'(step_done), 0);
    chk("abort_threshold", 32'(threshold), 32);
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", 32'(step_done), 0);
    end
  endtask

  initial begin
    reset = 1'b0; step_start = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
    cfg_threshold = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    done_allowed = 1'b0; got_spk = '0;
    model_reset();
    no_stalls();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_spike", 32'(out_spike), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_step_done", 32'(step_done), 0);
    chk("rst_spike_count", 32'(spike_count), 0);
    chk("rst_threshold", 32'(threshold), 32);
    tick();
    reset = 1'b1;

    set_stim(40, 10, 0, 255);
    run_step(0, 0, 0, 0);
    chk("A_spikes", 32'(got_spk), 0);
    chk("A_model_s0", m_s[0], 40);
    chk("A_model_s3", m_s[3], 255);

    set_stim(0, 0, 0, 0);
    run_step(0, 0, 0, 0);
    chk("B_spikes", 32'(got_spk), 9);
    chk("B_count", 32'(spike_count), 2);
    chk("B_model_s0", m_s[0], 2);
    chk("B_model_s3", m_s[3], 15);

    run_step(0, 0, 0, 0);
    chk("C_spikes", 32'(got_spk), 0);
    chk("C_model_s0", m_s[0], 0);
    chk("C_model_s3", m_s[3], 0);

    set_stim(255, 0, 0, 0);
    run_step(0, 0, 0, 0);
    set_stim(250, 0, 0, 0);
    run_step(0, 0, 0, 0);
    chk("E_model_sat", m_s[0], 255);

    set_stim(0, 0, 0, 0);
    in_st[0] = 3; out_st[0] = 5;
    run_step(0, 0, 0, 0);
    chk("F_sat_spike", 32'(got_spk), 1);
    no_stalls();

    set_stim(0, 12, 0, 0);
    run_step(0, 0, 0, 1);
    chk("G_thr_busy_ignored", 32'(threshold), 32);
    cfg_only(10);
    @(negedge clk);
    chk("cfg_idle_thr", 32'(threshold), 10);
    set_stim(0, 0, 0, 0);
    run_step(0, 0, 0, 0);
    chk("H_spikes", 32'(got_spk), 2);

    set_stim(100, 100, 100, 100);
    run_step(0, 0, 0, 0);
    abort_step();
    set_stim(0, 0, 0, 0);
    run_step(0, 0, 0, 0);
    chk("K_after_reset_spikes", 32'(got_spk), 0);

    set_stim(200, 200, 200, 200);
    run_step(0, 0, 0, 0);
    set_stim(0, 0, 0, 0);
    run_step(0, 0, 1, 0);
    chk("M_clr_with_start", 32'(got_spk), 15);
    set_stim(200, 200, 200, 200);
    run_step(0, 0, 0, 0);
    clear_only();
    set_stim(0, 0, 0, 0);
    run_step(0, 0, 0, 0);
    chk("P_after_clear", 32'(got_spk), 0);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom % 4)
          0:       stim[i] = 0;
          1:       stim[i] = SMAX;
          default: stim[i] = int'($urandom_range(0, SMAX));
        endcase
        in_st[i]  = int'($urandom_range(0, 2));
        out_st[i] = int'($urandom_range(0, 2));
      end
      if ($urandom % 6 == 0) clear_only();
      if ($urandom % 6 == 0) cfg_only(int'($urandom_range(0, 80)));
      run_step(($urandom % 4) == 0, int'($urandom_range(0, 80)), ($urandom % 4) == 0, ($urandom % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
